vector_lsu: RTL and testbench
=============================

Name: vector_lsu

Overview:
Memory-side counterpart of the vector ALU datapath. Serialises a 5-lane vector into word-wide memory writes (VSTR) or gathers word-wide memory reads into a 5-lane vector for the vector register file (VLDR). Sits between the vector register file, the data memory port and the controller, which stalls the core while busy is high. Strided addressing; active length uses the same 3-bit index as the vector ALU.

Parameters:
LANES, 5, number of vector lanes
WIDTH, 32, element and memory word width in bits
IDXW, 3, width of the active-length field

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
start  input  1  begin transfer; sampled only in IDLE
is_store  input  1  1 = vector store, 0 = vector load
index  input  IDXW  active element count; values above LANES clamp to LANES
base_addr  input  WIDTH  byte address of element 0
stride  input  WIDTH  byte increment between elements
store_data  input  LANES*WIDTH  flat store vector, lane i at [i*WIDTH +: WIDTH]
mem_req  output  1  memory access request
mem_we  output  1  write enable, valid with mem_req
mem_addr  output  WIDTH  access address
mem_wdata  output  WIDTH  store word
mem_rdata  input  WIDTH  load word, valid when mem_ack is high
mem_ack  input  1  access completes on this edge; may be high in the same cycle as mem_req
load_data  output  LANES*WIDTH  gathered load vector, flat, same lane layout as store_data
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, any state): state=IDLE; mem_req, mem_we, done, busy = 0; mem_addr, mem_wdata, load_data, element counter = 0. A transfer in flight is abandoned: no further requests are issued, and partial load data is cleared.
- FSM: IDLE -> XFER -> DONE -> IDLE.
- IDLE: on start=1, latch is_store, clamped length n, base_addr, stride and store_data. Clear load_data to 0. Set counter=0 and addr=base_addr.
  - If n=0, go to DONE with no memory access.
  - Otherwise go to XFER.
- XFER:
  - mem_req=1, mem_we=latched is_store, mem_addr=addr, mem_wdata=latched lane[counter].
  - Outputs are held stable while mem_ack=0.
  - On an edge with mem_ack=1: on a load, write mem_rdata into load_data lane[counter]. Then counter+=1 and addr+=stride, with mod-2^WIDTH wrap and no overflow flag.
  - When the acked element is element n-1, go to DONE.
- DONE: done=1, mem_req=0 for exactly one cycle, then IDLE. load_data holds its value until the next accepted start or reset.
- Timing with mem_ack tied high: start accepted at edge 0; element i occupies cycle i+1; done is high in cycle n+1. For n=0, done is high in cycle 1.
- start while busy is ignored. No queueing; the latched operands are unaffected.
- Lanes with index >= n of load_data read 0. On a store, lanes >= n are never written to memory.
- Address arithmetic is unsigned. A stride of 0 repeats the same address n times.

Decomposition:
- Shared package (vector_pkg): LANES, WIDTH, IDXW constants; lsu_state_t encoding (IDLE=2'd0, XFER=2'd1, DONE=2'd2); a lane-slice helper function.
- One natural sub-module: vlsu_addr_gen (base load, stride accumulate, element counter, last-element compare).
- The FSM and the load_data lane register stay in vector_lsu.

Test Plan:
- Store, n=5, base=0x100, stride=4, store_data lanes 0x11..0x55, ack tied high: writes to 0x100,0x104,0x108,0x10C,0x110 with 0x11..0x55 in cycles 1-5; done=1 in cycle 6.
- Load, n=3, base=0x200, stride=8, memory returns 0xA0,0xA1,0xA2, ack tied high: reads 0x200,0x208,0x210; load_data lanes = 0xA0,0xA1,0xA2,0,0; done=1 in cycle 4.
- index=0 and index=7: n=0 gives no mem_req and done in cycle 1. index=7 clamps to 5 accesses.
- Ack delayed 2 cycles per element on a load with n=2: mem_addr and mem_we hold stable while waiting; done in cycle 7; start pulsed during busy is ignored.
- base=0xFFFFFFFC, stride=4, n=2: addresses 0xFFFFFFFC then 0x00000000.
- reset asserted in the cycle element 1 is requested: next cycle mem_req=0, busy=0 and load_data=0; no done pulse.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared constants, FSM encoding and lane helper for the vector LSU.
package vector_pkg;

    localparam int LANES = 5;
    localparam int WIDTH = 32;
    localparam int IDXW  = 3;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_XFER = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

    // Pick lane i out of a flat vector; out-of-range lanes read as zero.
    function automatic logic [WIDTH-1:0] lane_get(input logic [LANES*WIDTH-1:0] v,
                                                  input logic [IDXW-1:0]        i);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            if (i == IDXW'(k)) r = v[k*WIDTH +: WIDTH];
        end
        return r;
    endfunction

endpackage

// File: rtl/vlsu_addr_gen.sv
// Strided address generator: loads base/stride/length, steps one element per
// acknowledged access, and flags the final element.
module vlsu_addr_gen
    import vector_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] base_i,
    input  logic [WIDTH-1:0] stride_i,
    input  logic [IDXW-1:0]  len_i,
    output logic [WIDTH-1:0] addr_o,
    output logic [IDXW-1:0]  cnt_o,
    output logic             last_o
);

    logic [WIDTH-1:0] addr_q, stride_q;
    logic [IDXW-1:0]  cnt_q, len_q;

    // Address accumulates stride with natural mod-2^WIDTH wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            stride_q <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
        end else if (load_i) begin
            addr_q   <= base_i;
            stride_q <= stride_i;
            cnt_q    <= '0;
            len_q    <= len_i;
        end else if (step_i) begin
            addr_q   <= addr_q + stride_q;
            cnt_q    <= cnt_q + IDXW'(1);
        end
    end

    assign addr_o = addr_q;
    assign cnt_o  = cnt_q;
    // Only consulted in XFER, where len_q is never zero.
    assign last_o = (cnt_q == len_q - IDXW'(1));

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store unit: serialises a vector store into word writes or
// gathers word reads into a vector, one element per acknowledged access.
module vector_lsu
    import vector_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   is_store,
    input  logic [IDXW-1:0]        index,
    input  logic [WIDTH-1:0]       base_addr,
    input  logic [WIDTH-1:0]       stride,
    input  logic [LANES*WIDTH-1:0] store_data,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [WIDTH-1:0]       mem_addr,
    output logic [WIDTH-1:0]       mem_wdata,
    input  logic [WIDTH-1:0]       mem_rdata,
    input  logic                   mem_ack,
    output logic [LANES*WIDTH-1:0] load_data,
    output logic                   busy,
    output logic                   done
);

    lsu_state_t             state_q, state_d;
    logic                   is_store_q;
    logic [LANES*WIDTH-1:0] store_q;
    logic [LANES*WIDTH-1:0] load_q;
    logic [IDXW-1:0]        n_len, cnt;
    logic [WIDTH-1:0]       addr;
    logic                   accept, step, last;

    // Lengths above the lane count saturate to a full vector.
    assign n_len = (index > IDXW'(LANES)) ? IDXW'(LANES) : index;

    vlsu_addr_gen u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .load_i   (accept),
        .step_i   (step),
        .base_i   (base_addr),
        .stride_i (stride),
        .len_i    (n_len),
        .addr_o   (addr),
        .cnt_o    (cnt),
        .last_o   (last)
    );

    // Next-state logic; start only matters in IDLE, ack only in XFER.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (n_len == '0) ? LSU_DONE : LSU_XFER;
                end
            end
            LSU_XFER: begin
                if (mem_ack) begin
                    step = 1'b1;
                    if (last) state_d = LSU_DONE;
                end
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= LSU_IDLE;
        else       state_q <= state_d;
    end

    // Operand latch and load gather; a new start wipes stale load lanes.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_store_q <= 1'b0;
            store_q    <= '0;
            load_q     <= '0;
        end else if (accept) begin
            is_store_q <= is_store;
            store_q    <= store_data;
            load_q     <= '0;
        end else if (step && !is_store_q) begin
            for (int k = 0; k < LANES; k++) begin
                if (cnt == IDXW'(k)) load_q[k*WIDTH +: WIDTH] <= mem_rdata;
            end
        end
    end

    assign mem_req   = (state_q == LSU_XFER);
    assign mem_we    = mem_req && is_store_q;
    assign mem_addr  = addr;
    assign mem_wdata = mem_req ? lane_get(store_q, cnt) : '0;
    assign load_data = load_q;
    assign busy      = (state_q != LSU_IDLE);
    assign done      = (state_q == LSU_DONE);

endmodule

// File: tb/tb_vector_lsu.sv
// Directed self-checking bench for vector_lsu.
module tb_vector_lsu;

    logic         clk = 1'b0;
    logic         reset, start, is_store, mem_ack;
    logic [2:0]   index;
    logic [31:0]  base_addr, stride, mem_rdata;
    logic [159:0] store_data, load_data;
    logic         mem_req, mem_we, busy, done;
    logic [31:0]  mem_addr, mem_wdata;

    int tests = 0;
    int fails = 0;

    vector_lsu dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store),
        .index(index), .base_addr(base_addr), .stride(stride),
        .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .load_data(load_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Small read-only memory image for the load tests.
    always_comb begin
        case (mem_addr)
            32'h200: mem_rdata = 32'hA0;
            32'h208: mem_rdata = 32'hA1;
            32'h210: mem_rdata = 32'hA2;
            default: mem_rdata = 32'hDEAD0000 | {16'h0, mem_addr[15:0]};
        endcase
    end

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic st, input logic [2:0] idx, input logic [31:0] b,
                      input logic [31:0] s);
        is_store = st; index = idx; base_addr = b; stride = s; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int reqs;
        logic [31:0] a;
        reset = 1'b1; start = 1'b0; is_store = 1'b0; mem_ack = 1'b1;
        index = '0; base_addr = '0; stride = '0;
        store_data = {32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
        tick(); tick();
        chk("rst_req",  mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ld",   load_data, 0);
        reset = 1'b0;
        tick();

        // Store n=5, base 0x100, stride 4
        go(1'b1, 3'd5, 32'h100, 32'h4);
        for (int i = 0; i < 5; i++) begin
            a = 32'h100 + 32'(4 * i);
            chk("st_req",   mem_req, 1);
            chk("st_we",    mem_we, 1);
            chk("st_addr",  mem_addr, a);
            chk("st_wdata", mem_wdata, 32'h11 * (i + 1));
            chk("st_done0", done, 0);
            tick();
        end
        chk("st_done", done, 1);
        chk("st_req_d", mem_req, 0);
        tick();
        chk("st_idle", busy, 0);

        // Load n=3, base 0x200, stride 8
        go(1'b0, 3'd3, 32'h200, 32'h8);
        for (int i = 0; i < 3; i++) begin
            chk("ld_req",  mem_req, 1);
            chk("ld_we",   mem_we, 0);
            chk("ld_addr", mem_addr, 32'h200 + 32'(8 * i));
            tick();
        end
        chk("ld_done", done, 1);
        chk("ld_data", load_data, {32'h0, 32'h0, 32'hA2, 32'hA1, 32'hA0});
        tick();

        // index=0: no access, done in cycle 1
        go(1'b1, 3'd0, 32'h300, 32'h4);
        chk("n0_req",  mem_req, 0);
        chk("n0_done", done, 1);
        chk("n0_ld",   load_data, 0);
        tick();
        chk("n0_idle", busy, 0);

        // index=7 clamps to 5 accesses
        go(1'b1, 3'd7, 32'h0, 32'h4);
        reqs = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (mem_req) reqs++;
            tick();
        end
        chk("n7_done", done, 1);
        chk("n7_reqs", reqs, 5);
        tick();

        // Load n=2 with ack delayed 2 cycles; start during busy ignored
        mem_ack = 1'b0;
        go(1'b0, 3'd2, 32'h200, 32'h8);
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 2; w++) begin
                chk("dl_req",  mem_req, 1);
                chk("dl_we",   mem_we, 0);
                chk("dl_addr", mem_addr, 32'h200 + 32'(8 * i));
                is_store = 1'b1; index = 3'd5; base_addr = 32'h999; start = 1'b1;
                tick();
            end
            start = 1'b0;
            mem_ack = 1'b1;
            chk("dl_hold", mem_addr, 32'h200 + 32'(8 * i));
            tick();
            mem_ack = 1'b0;
        end
        chk("dl_done", done, 1);
        chk("dl_data", load_data, {96'h0, 32'hA1, 32'hA0});
        mem_ack = 1'b1;
        tick();
        chk("dl_idle", busy, 0);

        // Address wrap
        go(1'b1, 3'd2, 32'hFFFFFFFC, 32'h4);
        chk("wr_a0", mem_addr, 32'hFFFFFFFC);
        tick();
        chk("wr_a1", mem_addr, 32'h0);
        tick();
        chk("wr_done", done, 1);
        tick();

        // Reset while element 1 is requested
        go(1'b0, 3'd5, 32'h200, 32'h8);
        tick();
        chk("rs_addr", mem_addr, 32'h208);
        chk("rs_part", load_data, {128'h0, 32'hA0});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_req",  mem_req, 0);
        chk("rs_busy", busy, 0);
        chk("rs_ld",   load_data, 0);
        for (int c = 0; c < 6; c++) begin
            chk("rs_nodone", done, 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
